// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between the SPI master and the register sequencer.
interface spi_reg_ctrl_if;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output cs_n, output mosi, input miso);
  modport slave  (input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI-domain byte sequencer: {rw, addr[6:0]} command then data burst into a register file.
// Define SPI_REG_BURST_EN for unlimited auto-increment bursts; otherwise one data byte per frame.
module spi_reg_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RO_BASE  = 12
) (
  input  logic                                sclk,
  input  logic                                rst,
  spi_reg_ctrl_if.slave                       spi,
  input  logic [(NUM_REGS-RO_BASE)*WIDTH-1:0] status_in,
  output logic [RO_BASE*WIDTH-1:0]            regs_flat,
  output logic                                wr_toggle,
  output logic [6:0]                          wr_addr,
  output logic                                frame_err
);

  localparam int unsigned AW         = 7;
  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);
  localparam logic [AW:0] RO_BASE_W  = (AW+1)'(RO_BASE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] MAX_ADDR  = {AW{1'b1}};

  localparam logic [1:0] ST_CMD       = 2'd0;
  localparam logic [1:0] ST_DATA      = 2'd1;
  localparam logic [1:0] ST_IDLE_FILL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q;
  logic [WIDTH-2:0] shift_q;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] out_sr_q;

  logic             byte_done_c;
  logic [WIDTH-1:0] byte_c;
  logic [AW-1:0]    next_addr_c;
  logic [AW-1:0]    rd_addr_c;
  logic [WIDTH-1:0] rd_data_c;
  logic             wr_en_c;
  logic             err_set_c;

  assign byte_done_c = (bit_cnt_q == 3'd7);
  assign byte_c      = {shift_q, spi.mosi};
  assign spi.miso    = out_sr_q[WIDTH-1];

  // Out-of-range addresses count up and stick at the top instead of wrapping.
  always_comb begin
    next_addr_c = addr_q + AW'(1);
    if (addr_q == LAST_ADDR)
      next_addr_c = '0;
    else if (addr_q == MAX_ADDR)
      next_addr_c = MAX_ADDR;
  end

  assign rd_addr_c = (state_q == ST_CMD) ? byte_c[AW-1:0] : next_addr_c;

  // Read mux over the writable file and the status inputs; unmapped reads return zero.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < RO_BASE; i++) begin
      if (rd_addr_c == AW'(i))
        rd_data_c = regs_flat[i*WIDTH +: WIDTH];
    end
    for (int unsigned i = RO_BASE; i < NUM_REGS; i++) begin
      if (rd_addr_c == AW'(i))
        rd_data_c = status_in[(i-RO_BASE)*WIDTH +: WIDTH];
    end
  end

  // Next-state and byte-boundary actions.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    wr_en_c   = 1'b0;
    err_set_c = 1'b0;
    if (byte_done_c) begin
      case (state_q)
        ST_CMD: begin
          rw_d      = byte_c[WIDTH-1];
          addr_d    = byte_c[AW-1:0];
          tx_d      = rd_data_c;
          err_set_c = ({1'b0, byte_c[AW-1:0]} >= NUM_REGS_W);
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          err_set_c = ({1'b0, addr_q} >= NUM_REGS_W);
          wr_en_c   = !rw_q && ({1'b0, addr_q} < RO_BASE_W);
          addr_d    = next_addr_c;
`ifdef SPI_REG_BURST_EN
          tx_d      = rd_data_c;
`else
          tx_d      = '0;
          state_d   = ST_IDLE_FILL;
`endif
        end
        ST_IDLE_FILL: begin
          tx_d = '0;
        end
        default: begin
          state_d = ST_CMD;
        end
      endcase
    end
  end

  // Frame state: cleared by reset or by chip-select deassertion.
  always_ff @(posedge sclk or posedge rst or posedge spi.cs_n) begin
    if (rst) begin
      state_q   <= ST_CMD;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      tx_q      <= '0;
    end else if (spi.cs_n) begin
      state_q   <= ST_CMD;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= byte_c[WIDTH-2:0];
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      tx_q      <= tx_d;
    end
  end

  // Persistent outputs survive chip-select; only reset clears them.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      regs_flat <= '0;
      wr_toggle <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else if (!spi.cs_n) begin
      if (wr_en_c) begin
        for (int unsigned i = 0; i < RO_BASE; i++) begin
          if (addr_q == AW'(i))
            regs_flat[i*WIDTH +: WIDTH] <= byte_c;
        end
        wr_addr   <= addr_q;
        wr_toggle <= !wr_toggle;
      end
      if (err_set_c)
        frame_err <= 1'b1;
    end
  end

  // MISO shifter: loads at each byte boundary so data leads the master's posedge sample.
  always_ff @(negedge sclk or posedge rst or posedge spi.cs_n) begin
    if (rst) begin
      out_sr_q <= '0;
    end else if (spi.cs_n) begin
      out_sr_q <= '0;
    end else if (bit_cnt_q == 3'd0) begin
      out_sr_q <= tx_q;
    end else begin
      out_sr_q <= {out_sr_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl; follows SPI_REG_BURST_EN to choose burst or single-byte model.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        rst;
  logic [31:0] status_in;
  logic [95:0] regs_flat;
  logic        wr_toggle;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_reg_ctrl_if spi ();

  spi_reg_ctrl #(.WIDTH(8), .NUM_REGS(16), .RO_BASE(12)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .spi       (spi),
    .status_in (status_in),
    .regs_flat (regs_flat),
    .wr_toggle (wr_toggle),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 sclk = ~sclk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mregs [12];
  logic       m_tog;
  logic [6:0] m_wr;
  logic       m_err;
  logic [7:0] fbytes [$];
  logic [7:0] exp_q  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    if (a < 7'd12) return mregs[a[3:0]];
    if (a < 7'd16) return status_in[(int'(a) - 12)*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [6:0] model_next(input logic [6:0] a);
    if (a == 7'd15)  return 7'd0;
    if (a == 7'd127) return 7'd127;
    return a + 7'd1;
  endfunction

  // Apply the frame to the model and queue the MISO byte expected for every byte slot.
  task automatic model_frame();
    logic [6:0] a;
    logic       rw;
    logic [7:0] tx;
    bit         idle;
    rw = fbytes[0][7];
    a  = fbytes[0][6:0];
    exp_q.push_back(8'h00);
    if (a >= 7'd16) m_err = 1'b1;
    tx   = model_rd(a);
    idle = 1'b0;
    for (int k = 1; k < fbytes.size(); k++) begin
      exp_q.push_back(tx);
      if (!idle) begin
        if (a >= 7'd16) m_err = 1'b1;
        if (!rw && a < 7'd12) begin
          mregs[a[3:0]] = fbytes[k];
          m_tog = ~m_tog;
          m_wr  = a;
        end
        a = model_next(a);
        if (BURST) tx = model_rd(a);
        else begin
          tx   = 8'h00;
          idle = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.mosi = b[i];
      rx = {rx[6:0], spi.miso};
      @(posedge sclk);
      @(negedge sclk);
      #1;
    end
  endtask

  task automatic run_frame();
    logic [7:0] rx;
    model_frame();
    @(negedge sclk);
    #1;
    spi.cs_n = 1'b0;
    for (int i = 0; i < fbytes.size(); i++) begin
      send_byte(fbytes[i], 8, rx);
      if (exp_q.size() > 0)
        check($sformatf("miso_b%0d_%02h", i, fbytes[0]), {24'h0, rx}, {24'h0, exp_q.pop_front()});
    end
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    @(negedge sclk);
    #1;
    check("miso_after_cs", {31'h0, spi.miso}, 32'h0);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_reg%0d", tag, i), {24'h0, regs_flat[i*8 +: 8]}, {24'h0, mregs[i]});
    check({tag, "_wr_toggle"}, {31'h0, wr_toggle}, {31'h0, m_tog});
    check({tag, "_wr_addr"},   {25'h0, wr_addr},   {25'h0, m_wr});
    check({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, m_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         n;
    rst       = 1'b1;
    spi.cs_n  = 1'b1;
    spi.mosi  = 1'b0;
    status_in = 32'hC3_5A_3C_96;
    for (int i = 0; i < 12; i++) mregs[i] = 8'h00;
    m_tog = 1'b0;
    m_wr  = 7'd0;
    m_err = 1'b0;

    repeat (3) @(negedge sclk);
    #1;
    check_state("reset");
    check("reset_miso", {31'h0, spi.miso}, 32'h0);
    rst = 1'b0;
    @(negedge sclk);
    #1;

    // Write burst then read it back.
    fbytes = {8'h02, 8'h11, 8'h22, 8'h33};
    run_frame();
    check_state("wr_burst");
    fbytes = {8'h82, 8'h00, 8'h00, 8'h00};
    run_frame();
    check_state("rd_burst");

    // Read across the top of the address space (15 -> 0).
    fbytes = {8'h00, 8'hAA};
    run_frame();
    fbytes = {8'h8F, 8'h00, 8'h00};
    run_frame();
    check_state("rd_wrap");

    // Write to read-only space is dropped; out-of-range read sets sticky error.
    fbytes = {8'h0C, 8'h55};
    run_frame();
    check_state("ro_write");
    fbytes = {8'h90, 8'h00};
    run_frame();
    check_state("oor_read");
    @(negedge sclk);
    #1;
    spi.cs_n = 1'b0;
    #2;
    spi.cs_n = 1'b1;
    repeat (2) @(negedge sclk);
    #1;
    check_state("err_sticky");

    // Abort mid data byte: nothing committed.
    fbytes = {8'h01};
    model_frame();
    @(negedge sclk);
    #1;
    spi.cs_n = 1'b0;
    send_byte(8'h01, 8, rx);
    check("abort_cmd_miso", {24'h0, rx}, {24'h0, exp_q.pop_front()});
    send_byte(8'hF0, 4, rx);
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    @(negedge sclk);
    #1;
    check_state("abort");
    fbytes = {8'h01, 8'h77};
    run_frame();
    check_state("after_abort");

    // Second data byte lands only in burst builds.
    fbytes = {8'h00, 8'h12, 8'h34};
    run_frame();
    check_state("two_data");

    // Randomised frames over in-range, read-only and out-of-range addresses.
    for (int f = 0; f < 10; f++) begin
      status_in = $urandom;
      n = $urandom_range(1, 4);
      fbytes.delete();
      fbytes.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))});
      for (int k = 0; k < n; k++) fbytes.push_back(8'($urandom));
      run_frame();
      check_state($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
